// File: rtl/seq_match_logger.sv
// Timestamps the match pulses of a serial sequence detector with a free-running bit
// position. The stamps go into a show-ahead FIFO that the host drains with valid/ready.
module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     match_in,
  output logic [TS_W-1:0]          ts_data,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         match_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0]  pos_q, pos_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [TS_W-1:0]  mem_q [DEPTH];
  logic [TS_W-1:0]  mem_d [DEPTH];

  logic [AW:0] level;
  logic        empty, full, push, pop, wr_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign push  = match_in & ~clear;
  assign pop   = ~empty & ts_ready & ~clear;
  // A pop on a full FIFO frees the slot for the push that arrives in the same cycle.
  assign wr_en = push & (~full | pop);

  always_comb begin
    pos_d    = pos_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;
    if (clear) begin
      pos_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      pos_d = pos_q + 1'b1;
      if (wr_en) begin
        mem_d[wr_ptr_q[AW-1:0]] = pos_q;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
        cnt_d = sat_inc(cnt_q);
      end
      if (push && full && !pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // The storage array carries data only; the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ts_valid    = ~empty;
  assign ts_data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_level  = level;
  assign match_count = cnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_match_logger.sv
// Scoreboard bench for seq_match_logger. The stimulus queues the expected timestamps.
// A monitor pops one of them each time the DUT hands an entry to the host.
module tb_seq_match_logger;

  logic        clk = 1'b0;
  logic        reset, clear, match_in, ts_ready;
  logic [15:0] ts_data;
  logic        ts_valid;
  logic [2:0]  fifo_level;
  logic [7:0]  match_count;
  logic        overflow;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] tb_pos;

  seq_match_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .match_in(match_in),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .fifo_level(fifo_level), .match_count(match_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Bit position the detector is presenting in the current cycle.
  always @(posedge clk or posedge reset) begin
    if (reset)      tb_pos <= '0;
    else if (clear) tb_pos <= '0;
    else            tb_pos <= tb_pos + 16'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && !clear && ts_valid && ts_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL pop_unexpected: got %0d, expected no entry", ts_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("pop_ts", int'(ts_data), int'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise match_in for the single cycle in which the position equals p.
  task automatic pulse(input int p, input bit store);
    int guard;
    guard = 0;
    while (tb_pos != 16'(p) && guard < 70000) begin
      step();
      guard++;
    end
    if (guard >= 70000) begin
      n_vec++;
      n_bad++;
      $display("FAIL pos_timeout: got %0d, expected %0d", tb_pos, p);
    end
    match_in = 1'b1;
    if (store) exp_q.push_back(16'(p));
    step();
    match_in = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Leaves entries 3 and 4 queued with overflow set.
  task automatic setup_two_with_ovf();
    ts_ready = 1'b0;
    pulse(1, 1); pulse(2, 1); pulse(3, 1); pulse(4, 1);
    pulse(5, 0);
    ts_ready = 1'b1;
    step(); step();
    ts_ready = 1'b0;
    chk("setup_level", fifo_level, 2);
    chk("setup_ovf", overflow, 1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; match_in = 1'b0; ts_ready = 1'b0;
    step(); step();
    chk("rst_valid", ts_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_data", ts_data, 0);
    chk("rst_count", match_count, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;

    // Two isolated matches with the host always ready
    ts_ready = 1'b1;
    pulse(5, 1);
    pulse(9, 1);
    step(); step();
    chk("t1_count", match_count, 2);
    chk("t1_ovf", overflow, 0);
    chk("t1_level", fifo_level, 0);
    chk("t1_valid", ts_valid, 0);

    // Fill while stalled, drop the fifth, then drain
    do_clear();
    chk("clr_count", match_count, 0);
    ts_ready = 1'b0;
    pulse(3, 1); pulse(4, 1); pulse(6, 1); pulse(8, 1);
    pulse(10, 0);
    chk("t2_level", fifo_level, 4);
    chk("t2_ovf", overflow, 1);
    chk("t2_count", match_count, 5);
    chk("t2_head_hold", ts_data, 3);
    ts_ready = 1'b1;
    repeat (5) step();
    chk("t2_valid_after", ts_valid, 0);
    chk("t2_ovf_sticky", overflow, 1);
    chk("t2_level_after", fifo_level, 0);

    // Full FIFO: push and pop in the same cycle
    do_clear();
    ts_ready = 1'b0;
    pulse(1, 1); pulse(2, 1); pulse(3, 1); pulse(4, 1);
    while (tb_pos != 16'd6) step();
    match_in = 1'b1; ts_ready = 1'b1;
    exp_q.push_back(16'd6);
    step();
    match_in = 1'b0; ts_ready = 1'b0;
    chk("t3_level", fifo_level, 4);
    chk("t3_ovf", overflow, 0);
    chk("t3_count", match_count, 5);
    chk("t3_head", ts_data, 2);
    ts_ready = 1'b1;
    repeat (6) step();
    chk("t3_level_after", fifo_level, 0);

    // Position counter wrap
    do_clear();
    pulse(65535, 1);
    pulse(0, 1);
    repeat (3) step();
    chk("t4_count", match_count, 2);

    // Saturation of the match counter
    do_clear();
    match_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(tb_pos);
      step();
    end
    match_in = 1'b0;
    repeat (3) step();
    chk("t5_count_sat", match_count, 255);
    chk("t5_ovf", overflow, 0);
    pulse(int'(tb_pos) + 2, 1);
    step(); step();
    chk("t5_count_hold", match_count, 255);

    // Synchronous clear with a match in the same cycle
    do_clear();
    setup_two_with_ovf();
    clear = 1'b1; match_in = 1'b1;
    step();
    clear = 1'b0; match_in = 1'b0;
    exp_q.delete();
    chk("t6_valid", ts_valid, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_count", match_count, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_data", ts_data, 0);
    ts_ready = 1'b1;
    pulse(0, 1);
    step(); step();
    chk("t6_level_after", fifo_level, 0);

    // Asynchronous reset between clock edges
    do_clear();
    setup_two_with_ovf();
    #3 reset = 1'b1;
    #1;
    chk("t7_valid", ts_valid, 0);
    chk("t7_level", fifo_level, 0);
    chk("t7_count", match_count, 0);
    chk("t7_ovf", overflow, 0);
    chk("t7_data", ts_data, 0);
    exp_q.delete();
    step();
    reset = 1'b0;
    ts_ready = 1'b1;
    pulse(0, 1);
    repeat (3) step();
    chk("t7_level_after", fifo_level, 0);
    chk("t7_count_after", match_count, 1);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
